// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: pointer width, depth and the
// full/empty tests on wrap-bit pointers.
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend into ptr_t.
    localparam int unsigned PTR_MAX_W    = 32;
    localparam int unsigned DEF_ADDRSIZE = 4;
    localparam int unsigned DEF_DEPTH    = 1 << DEF_ADDRSIZE;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    // Pointers carry one extra wrap bit above the storage address.
    function automatic int unsigned ptr_width(input int unsigned addrsize);
        return addrsize + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 1 << addrsize;
    endfunction

    // Bits of a pointer that are meaningful for a given address size.
    function automatic ptr_t ptr_mask(input int unsigned addrsize);
        return (ptr_t'(2) << addrsize) - ptr_t'(1);
    endfunction

    // Empty: both pointers identical including the wrap bit.
    function automatic logic fifo_empty(input ptr_t wptr, input ptr_t rptr,
                                        input int unsigned addrsize);
        return ((wptr ^ rptr) & ptr_mask(addrsize)) == '0;
    endfunction

    // Full: wrap bits differ, storage address bits equal.
    function automatic logic fifo_full(input ptr_t wptr, input ptr_t rptr,
                                       input int unsigned addrsize);
        return ((wptr ^ rptr) & ptr_mask(addrsize)) == (ptr_t'(1) << addrsize);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one combinational read port.
// The array is deliberately not reset.
module fifo_ram #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata_raw
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem_q [DEPTH];

    // Store the write word on an accepted write.
    always_ff @(posedge wclk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_raw = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: pointers, occupancy, registered flags,
// sticky error flags and an optional registered read port.
module sync_fifo_ctl
    import fifo_pkg::*;
#(
    parameter int DATASIZE   = 8,
    parameter int ADDRSIZE   = DEF_ADDRSIZE,
    parameter int AFULL_LVL  = (1 << ADDRSIZE) - 2,
    parameter int AEMPTY_LVL = 2,
    parameter bit OUTREG     = 1'b0
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int PTR_W = int'(ptr_width(ADDRSIZE));

    localparam logic [PTR_W-1:0] AFULL_CNT  = PTR_W'(AFULL_LVL);
    localparam logic [PTR_W-1:0] AEMPTY_CNT = PTR_W'(AEMPTY_LVL);
    localparam logic [PTR_W-1:0] CNT_ONE    = PTR_W'(1);
    localparam logic             AFULL_RST  = (AFULL_LVL == 0);

    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                afull_q, afull_d;
    logic                aempty_q, aempty_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                we;
    logic                re;
    logic [DATASIZE-1:0] rdata_raw;

    // Accept/reject decisions and next-state pointers, count and flags.
    always_comb begin
        we = winc & ~full_q;
        re = rinc & ~empty_q;

        wptr_d = wptr_q + PTR_W'(we);
        rptr_d = rptr_q + PTR_W'(re);

        unique case ({we, re})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d   = fifo_full(ptr_t'(wptr_d), ptr_t'(rptr_d), ADDRSIZE);
        empty_d  = fifo_empty(ptr_t'(wptr_d), ptr_t'(rptr_d), ADDRSIZE);
        afull_d  = (count_d >= AFULL_CNT);
        aempty_d = (count_d <= AEMPTY_CNT);

        // Attempts against a full/empty FIFO latch until reset.
        ovf_d = ovf_q | (winc & full_q);
        unf_d = unf_q | (rinc & empty_q);
    end

    // Controller state; all of it returns to idle-empty on reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= AFULL_RST;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_ram #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_ram (
        .wclk      (wclk),
        .we        (we),
        .waddr     (wptr_q[ADDRSIZE-1:0]),
        .wdata     (wdata),
        .raddr     (rptr_q[ADDRSIZE-1:0]),
        .rdata_raw (rdata_raw)
    );

    generate
        if (OUTREG) begin : g_outreg
            logic [DATASIZE-1:0] rdata_q;

            // Capture the head word on an accepted read; hold otherwise.
            always_ff @(posedge wclk or posedge wrst) begin
                if (wrst) begin
                    rdata_q <= '0;
                end else if (re) begin
                    rdata_q <= rdata_raw;
                end
            end

            assign rdata = rdata_q;
        end else begin : g_showahead
            assign rdata = rdata_raw;
        end
    endgenerate

    assign wfull         = full_q;
    assign rempty        = empty_q;
    assign walmost_full  = afull_q;
    assign ralmost_empty = aempty_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: a show-ahead and a registered-output instance share
// stimulus and are compared every cycle against a queue model.
module tb_sync_fifo_ctl;

    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic       wclk = 1'b0;
    logic       wrst = 1'b1;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata0, rdata1;
    logic       wfull0, wfull1, rempty0, rempty1;
    logic       afull0, afull1, aempty0, aempty1;
    logic [4:0] count0, count1;
    logic       ovf0, ovf1, unf0, unf1;

    sync_fifo_ctl #(.DATASIZE(8), .ADDRSIZE(4), .OUTREG(1'b0)) dut0 (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata0), .wfull(wfull0), .rempty(rempty0),
        .walmost_full(afull0), .ralmost_empty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_ctl #(.DATASIZE(8), .ADDRSIZE(4), .OUTREG(1'b1)) dut1 (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .rdata(rdata1), .wfull(wfull1), .rempty(rempty1),
        .walmost_full(afull1), .ralmost_empty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    always #5 wclk = ~wclk;

    // Reference model: FIFO contents as a queue plus sticky flags.
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    logic [7:0] m_rd1 = 8'h00;
    bit         cmp_en = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit w, input logic [7:0] d, input bit r);
        bit full;
        bit empty;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (w && full)  m_ovf = 1'b1;
        if (r && empty) m_unf = 1'b1;
        if (r && !empty) m_rd1 = mq.pop_front();
        if (w && !full)  mq.push_back(d);
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rd1 = 8'h00;
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r);
        @(negedge wclk);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge wclk);
        model_step(w, d, r);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    // Reset pulse placed between clock edges to exercise the async path.
    task automatic do_reset();
        @(posedge wclk);
        #2;
        wrst = 1'b1;
        #1;
        chk("async_count0", count0, 0);
        chk("async_rempty0", rempty0, 1);
        chk("async_count1", count1, 0);
        chk("async_rempty1", rempty1, 1);
        model_clear();
        #1;
        wrst = 1'b0;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge wclk) begin
        int n;
        if (cmp_en && !wrst) begin
            n = mq.size();
            chk("count0", count0, n);
            chk("count1", count1, n);
            chk("wfull0", wfull0, n == DEPTH);
            chk("wfull1", wfull1, n == DEPTH);
            chk("rempty0", rempty0, n == 0);
            chk("rempty1", rempty1, n == 0);
            chk("afull0", afull0, n >= AFL);
            chk("afull1", afull1, n >= AFL);
            chk("aempty0", aempty0, n <= AEL);
            chk("aempty1", aempty1, n <= AEL);
            chk("ovf0", ovf0, m_ovf);
            chk("ovf1", ovf1, m_ovf);
            chk("unf0", unf0, m_unf);
            chk("unf1", unf1, m_unf);
            if (n > 0) chk("rdata0", rdata0, mq[0]);
            chk("rdata1", rdata1, m_rd1);
        end
    end

    initial begin
        int pw;
        int pr;
        #12;
        wrst = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("rst_rempty", rempty0, 1);
        chk("rst_wfull", wfull0, 0);
        chk("rst_count", count0, 0);
        chk("rst_aempty", aempty0, 1);
        chk("rst_ovf", ovf0, 0);
        chk("rst_unf", unf0, 0);
        chk("rst_rdata1", rdata1, 8'h00);

        // Partial fill, then asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        chk("fill5_count", count0, 5);
        do_reset();

        // Fill to full, then one dropped write.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            chk("fill_afull", afull0, (i + 1) >= 14);
        end
        chk("full_wfull", wfull0, 1);
        chk("full_count", count0, 16);
        cycle(1'b1, 8'hAA, 1'b0);
        chk("ovf_set", ovf0, 1);
        chk("ovf_count", count0, 16);

        // Drain: show-ahead word visible before each read.
        for (int i = 0; i < 16; i++) begin
            chk("showahead", rdata0, 8'(i));
            cycle(1'b0, 8'h00, 1'b1);
            chk("outreg_drain", rdata1, 8'(i));
        end
        chk("drain_rempty", rempty0, 1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("unf_set", unf0, 1);

        // Registered read latency.
        do_reset();
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        chk("outreg_idle0", rdata1, 8'h00);
        cycle(1'b0, 8'h00, 1'b1);
        chk("outreg_r1", rdata1, 8'h11);
        cycle(1'b0, 8'h00, 1'b1);
        chk("outreg_r2", rdata1, 8'h22);
        cycle(1'b0, 8'h00, 1'b0);
        chk("outreg_hold", rdata1, 8'h22);

        // Simultaneous write and read at empty, mid and full.
        do_reset();
        cycle(1'b1, 8'h5A, 1'b1);
        chk("simul_empty", count0, 1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        cycle(1'b1, 8'h70, 1'b1);
        chk("simul_mid", count0, 8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        chk("simul_prefull", wfull0, 1);
        cycle(1'b1, 8'hEE, 1'b1);
        chk("simul_full", count0, 15);
        chk("simul_full_wfull", wfull0, 0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);

        // Pointer wrap with steady occupancy of 3.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b1);
        chk("wrap_count", count0, 3);
        chk("wrap_rempty", rempty0, 0);
        chk("wrap_wfull", wfull0, 0);

        // Random traffic with shifting write/read bias.
        do_reset();
        pw = 50;
        pr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pw = int'($urandom_range(10, 90));
                pr = int'($urandom_range(10, 90));
            end
            if (i == 1500) do_reset();
            cycle(int'($urandom_range(0, 99)) < pw, 8'($urandom),
                  int'($urandom_range(0, 99)) < pr);
        end

        @(negedge wclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
